multicycle_control: RTL and testbench

MULTICYCLE_CONTROL -- requirements
Module: multicycle_control

---
 rtl/multicycle_control.sv | 167 ++++++++++++++++
 tb/tb_multicycle_control.sv | 286 ++++++++++++++++++++++++++++
 2 files changed

// File: rtl/multicycle_control.sv
// Multicycle control unit: a six-state FSM that sequences fetch, decode,
// execute, memory and write-back, and owns the PC and instruction registers.
// Every output is decoded from the registered state and ir. rst only gates
// the strobes; mem_ready, zero_out and instrn never reach an output directly.
module multicycle_control #(
   parameter int unsigned       DATA_W   = 32,
   parameter logic [DATA_W-1:0] RESET_PC = '0
) (
   input  logic              clk,
   input  logic              rst,
   input  logic [31:0]       instrn,
   input  logic              mem_ready,
   input  logic              zero_out,
   input  logic [DATA_W-1:0] branch_address,
   input  logic [DATA_W-1:0] jump_address,
   output logic [DATA_W-1:0] pc,
   output logic [31:0]       ir,
   output logic              mem_req,
   output logic              mem_we,
   output logic              mem_addr_sel,
   output logic              ctrl_write_en,
   output logic [4:0]        ctrl_write_addr,
   output logic              ctrl_regwrite_sel,
   output logic              ctrl_aluin2_sel,
   output logic              retire,
   output logic              illegal,
   output logic [2:0]        state
);

   typedef enum logic [2:0] {
      S_FETCH  = 3'd0,
      S_DECODE = 3'd1,
      S_EXEC   = 3'd2,
      S_MEM    = 3'd3,
      S_WB     = 3'd4,
      S_TRAP   = 3'd5
   } state_t;

   localparam logic [5:0] OP_R    = 6'h00;
   localparam logic [5:0] OP_J    = 6'h02;
   localparam logic [5:0] OP_BEQ  = 6'h04;
   localparam logic [5:0] OP_ADDI = 6'h08;
   localparam logic [5:0] OP_LW   = 6'h23;
   localparam logic [5:0] OP_SW   = 6'h2B;

   localparam logic [DATA_W-1:0] PC_STEP = DATA_W'(4);

   state_t            state_q, state_d;
   logic [DATA_W-1:0] pc_q, pc_d;
   logic [31:0]       ir_q, ir_d;
   logic              illegal_q, illegal_d;
   logic              retire_q, retire_d;

   logic [5:0]        opcode;
   logic [4:0]        wb_addr;

   assign opcode  = ir_q[31:26];
   // R-type writes rd; immediate forms and loads write rt.
   assign wb_addr = (opcode == OP_R) ? ir_q[15:11] : ir_q[20:16];

   // State, PC, IR and flag registers; reset wins over any transition.
   always_ff @(posedge clk) begin
      if (rst) begin
         state_q   <= S_FETCH;
         pc_q      <= RESET_PC;
         ir_q      <= '0;
         illegal_q <= 1'b0;
         retire_q  <= 1'b0;
      end else begin
         state_q   <= state_d;
         pc_q      <= pc_d;
         ir_q      <= ir_d;
         illegal_q <= illegal_d;
         retire_q  <= retire_d;
      end
   end

   // Next-state, PC/IR update, and the retire pulse that lands on FETCH entry.
   always_comb begin
      state_d   = state_q;
      pc_d      = pc_q;
      ir_d      = ir_q;
      illegal_d = illegal_q;
      retire_d  = 1'b0;
      case (state_q)
         S_FETCH: begin
            if (mem_ready) begin
               ir_d    = instrn;
               pc_d    = pc_q + PC_STEP;
               state_d = S_DECODE;
            end
         end
         S_DECODE: begin
            case (opcode)
               OP_J: begin
                  pc_d     = jump_address;
                  retire_d = 1'b1;
                  state_d  = S_FETCH;
               end
               OP_R, OP_BEQ, OP_ADDI, OP_LW, OP_SW: state_d = S_EXEC;
               default: begin
                  illegal_d = 1'b1;
                  state_d   = S_TRAP;
               end
            endcase
         end
         S_EXEC: begin
            case (opcode)
               OP_BEQ: begin
                  if (zero_out) begin
                     pc_d = branch_address;
                  end
                  retire_d = 1'b1;
                  state_d  = S_FETCH;
               end
               OP_LW, OP_SW: state_d = S_MEM;
               default:      state_d = S_WB;
            endcase
         end
         S_MEM: begin
            if (mem_ready) begin
               if (opcode == OP_SW) begin
                  retire_d = 1'b1;
                  state_d  = S_FETCH;
               end else begin
                  state_d = S_WB;
               end
            end
         end
         S_WB: begin
            retire_d = 1'b1;
            state_d  = S_FETCH;
         end
         S_TRAP: state_d = S_TRAP;
         default: state_d = S_TRAP;
      endcase
   end

   // Output decode from registered state and ir; strobes are forced low in reset.
   always_comb begin
      mem_req           = 1'b0;
      mem_we            = 1'b0;
      mem_addr_sel      = 1'b0;
      ctrl_write_en     = 1'b0;
      ctrl_write_addr   = wb_addr;
      ctrl_regwrite_sel = (opcode == OP_LW);
      // Kept valid through MEM too, so the ALU address stays stable there.
      ctrl_aluin2_sel   = (opcode == OP_ADDI) || (opcode == OP_LW) || (opcode == OP_SW);
      case (state_q)
         S_FETCH: mem_req = ~rst;
         S_MEM: begin
            mem_req      = ~rst;
            mem_addr_sel = 1'b1;
            mem_we       = ~rst & (opcode == OP_SW);
         end
         S_WB: ctrl_write_en = ~rst & (wb_addr != 5'd0);
         default: ;
      endcase
   end

   assign retire  = retire_q & ~rst;
   assign pc      = pc_q;
   assign ir      = ir_q;
   assign illegal = illegal_q;
   assign state   = state_q;

endmodule

// File: tb/tb_multicycle_control.sv
// Bench for multicycle_control: a 32-bit instance plus an 8-bit instance
// (reset PC 0xFC) sharing one stimulus stream. Expected results are queued
// before each instruction is driven and popped when the DUT retires it.
module tb_multicycle_control;

   localparam logic [31:0] RPC  = 32'h100;
   localparam logic [7:0]  RPC8 = 8'hFC;

   logic        clk = 1'b0;
   logic        rst = 1'b1;
   logic        mem_ready = 1'b0;
   logic        zero_out = 1'b0;
   logic [31:0] instrn = '0;
   logic [31:0] branch_address = '0;
   logic [31:0] jump_address = '0;

   logic [31:0] pc, ir;
   logic        mem_req, mem_we, mem_addr_sel, ctrl_write_en;
   logic [4:0]  ctrl_write_addr;
   logic        ctrl_regwrite_sel, ctrl_aluin2_sel, retire, illegal;
   logic [2:0]  state;

   logic [7:0]  pc8;
   logic [31:0] ir8;
   logic        mem_req8, mem_we8, mem_addr_sel8, ctrl_write_en8;
   logic [4:0]  ctrl_write_addr8;
   logic        ctrl_regwrite_sel8, ctrl_aluin2_sel8, retire8, illegal8;
   logic [2:0]  state8;

   int n_tests = 0;
   int n_fail  = 0;
   logic [31:0] pc_model;

   typedef struct {
      logic [31:0] pc;
      logic [7:0]  pc8;
      int          cycles;
      logic [29:0] trace;
      logic        we;
      logic [4:0]  waddr;
      logic        rsel;
      logic        alu2;
      int          mem_cycles;
      logic        mem_we;
      logic        bad;
      logic        retire_after;
   } rec_t;

   rec_t exp_q[$];

   always #5 clk = ~clk;

   multicycle_control #(.DATA_W(32), .RESET_PC(RPC)) dut (
      .clk(clk), .rst(rst), .instrn(instrn), .mem_ready(mem_ready), .zero_out(zero_out),
      .branch_address(branch_address), .jump_address(jump_address),
      .pc(pc), .ir(ir), .mem_req(mem_req), .mem_we(mem_we), .mem_addr_sel(mem_addr_sel),
      .ctrl_write_en(ctrl_write_en), .ctrl_write_addr(ctrl_write_addr),
      .ctrl_regwrite_sel(ctrl_regwrite_sel), .ctrl_aluin2_sel(ctrl_aluin2_sel),
      .retire(retire), .illegal(illegal), .state(state)
   );

   multicycle_control #(.DATA_W(8), .RESET_PC(RPC8)) dut8 (
      .clk(clk), .rst(rst), .instrn(instrn), .mem_ready(mem_ready), .zero_out(zero_out),
      .branch_address(branch_address[7:0]), .jump_address(jump_address[7:0]),
      .pc(pc8), .ir(ir8), .mem_req(mem_req8), .mem_we(mem_we8), .mem_addr_sel(mem_addr_sel8),
      .ctrl_write_en(ctrl_write_en8), .ctrl_write_addr(ctrl_write_addr8),
      .ctrl_regwrite_sel(ctrl_regwrite_sel8), .ctrl_aluin2_sel(ctrl_aluin2_sel8),
      .retire(retire8), .illegal(illegal8), .state(state8)
   );

   task automatic step();
      @(posedge clk);
      #1;
   endtask

   task automatic push_exp(input logic [31:0] epc, input int cyc, input logic [29:0] tr,
                           input logic we, input logic [4:0] wa, input logic rs,
                           input logic a2, input int mc, input logic mwe);
      rec_t e;
      e.pc = epc; e.pc8 = '0; e.cycles = cyc; e.trace = tr; e.we = we; e.waddr = wa;
      e.rsel = rs; e.alu2 = a2; e.mem_cycles = mc; e.mem_we = mwe; e.bad = 1'b0;
      e.retire_after = 1'b0;
      exp_q.push_back(e);
   endtask

   // Runs one instruction from FETCH until retire (bounded), recording what the DUT did.
   task automatic drive(input logic [31:0] ins, input int fw, input int mw, input logic zf,
                        output rec_t o);
      int fcnt = 0;
      int mcnt = 0;
      bit done = 0;
      o.pc = '0; o.pc8 = '0; o.cycles = 0; o.trace = '0; o.we = 0; o.waddr = '0; o.rsel = 0;
      o.alu2 = 0; o.mem_cycles = 0; o.mem_we = 0; o.bad = 0; o.retire_after = 0;
      instrn = ins;
      zero_out = zf;
      for (int c = 0; c < 64; c++) begin
         mem_ready = 1'b0;
         if (state == 3'd0) begin
            mem_ready = (fcnt >= fw);
            fcnt++;
            if (!mem_req || mem_addr_sel || mem_we) o.bad = 1'b1;
         end else if (state == 3'd3) begin
            mem_ready = (mcnt >= mw);
            mcnt++;
            o.mem_cycles++;
            if (mem_we) o.mem_we = 1'b1;
            if (!mem_req || !mem_addr_sel) o.bad = 1'b1;
         end else if (mem_req || mem_we) begin
            o.bad = 1'b1;
         end
         if (state == 3'd2) o.alu2 = ctrl_aluin2_sel;
         if (ctrl_write_en) begin
            if (state != 3'd4) o.bad = 1'b1;
            o.we = 1'b1;
            o.waddr = ctrl_write_addr;
            o.rsel = ctrl_regwrite_sel;
         end
         o.trace = (o.trace << 3) | 30'(state);
         step();
         o.cycles++;
         if (retire) begin
            done = 1;
            break;
         end
      end
      if (!done) o.cycles = -1;
      o.pc = pc;
      o.pc8 = pc8;
      mem_ready = 1'b0;
      step();
      o.retire_after = retire;
   endtask

   task automatic test_reset();
      rst = 1'b1;
      step();
      step();
      n_tests++; if (state !== 3'd0) begin n_fail++; $display("FAIL reset_state got %0d want 0", state); end
      n_tests++; if (pc !== RPC) begin n_fail++; $display("FAIL reset_pc got %h want %h", pc, RPC); end
      n_tests++; if (ir !== 32'h0) begin n_fail++; $display("FAIL reset_ir got %h want 0", ir); end
      n_tests++; if (illegal !== 1'b0) begin n_fail++; $display("FAIL reset_illegal got %b want 0", illegal); end
      n_tests++; if ({mem_req, mem_we, ctrl_write_en, retire} !== 4'b0) begin
         n_fail++; $display("FAIL reset_strobes got %b want 0000", {mem_req, mem_we, ctrl_write_en, retire}); end
      n_tests++; if (pc8 !== RPC8) begin n_fail++; $display("FAIL reset_pc8 got %h want %h", pc8, RPC8); end
      n_tests++; if ({state8, ir8, illegal8, mem_req8, mem_we8, ctrl_write_en8, retire8} !== '0) begin
         n_fail++; $display("FAIL reset_dut8 got state %0d ir %h illegal %b", state8, ir8, illegal8); end
      rst = 1'b0;
      #1;
      n_tests++; if (mem_req !== 1'b1) begin n_fail++; $display("FAIL fetch_req got %b want 1", mem_req); end
      pc_model = RPC;
      $display("[TB] reset: state=%0d pc=%h pc8=%h", state, pc, pc8);
   endtask

   task automatic test_alu();
      logic [31:0] ins[4] = '{32'h012A4020, 32'h21280005, 32'h21200005, 32'h012A4020};
      int          fw[4]  = '{0, 0, 0, 2};
      logic        we[4]  = '{1'b1, 1'b1, 1'b0, 1'b1};
      logic [4:0]  wa[4]  = '{5'd8, 5'd8, 5'd0, 5'd8};
      logic        a2[4]  = '{1'b0, 1'b1, 1'b1, 1'b0};
      rec_t o, e;
      for (int i = 0; i < 4; i++) begin
         pc_model = pc_model + 32'd4;
         push_exp(pc_model, 4 + fw[i], 30'o124, we[i], wa[i], 1'b0, a2[i], 0, 1'b0);
         drive(ins[i], fw[i], 0, 1'b0, o);
         e = exp_q.pop_front();
         n_tests++; if (o.pc !== e.pc) begin n_fail++; $display("FAIL alu%0d_pc got %h want %h", i, o.pc, e.pc); end
         n_tests++; if (o.cycles != e.cycles) begin n_fail++; $display("FAIL alu%0d_cycles got %0d want %0d", i, o.cycles, e.cycles); end
         n_tests++; if (o.trace !== e.trace) begin n_fail++; $display("FAIL alu%0d_trace got %o want %o", i, o.trace, e.trace); end
         n_tests++; if (o.we !== e.we || o.waddr !== e.waddr || o.rsel !== e.rsel) begin
            n_fail++; $display("FAIL alu%0d_wb got we%b a%0d s%b want we%b a%0d s%b", i, o.we, o.waddr, o.rsel, e.we, e.waddr, e.rsel); end
         n_tests++; if (o.alu2 !== e.alu2) begin n_fail++; $display("FAIL alu%0d_aluin2 got %b want %b", i, o.alu2, e.alu2); end
         n_tests++; if (o.bad !== 1'b0 || o.retire_after !== 1'b0) begin
            n_fail++; $display("FAIL alu%0d_protocol got bad=%b retire_after=%b want 0 0", i, o.bad, o.retire_after); end
         if (i == 0) begin
            n_tests++; if (o.pc8 !== 8'h00) begin n_fail++; $display("FAIL pc8_wrap got %h want 00", o.pc8); end
         end
         $display("[TB] alu%0d ins=%h pc=%h cycles=%0d we=%b addr=%0d", i, ins[i], o.pc, o.cycles, o.we, o.waddr);
      end
   endtask

   task automatic test_load_store();
      logic [31:0] ins[2] = '{32'hAD090008, 32'h8D090004};
      int          mw[2]  = '{0, 3};
      int          cyc[2] = '{4, 8};
      logic [29:0] tr[2]  = '{30'o123, 30'o1233334};
      rec_t o, e;
      for (int i = 0; i < 2; i++) begin
         pc_model = pc_model + 32'd4;
         push_exp(pc_model, cyc[i], tr[i], i == 1, (i == 1) ? 5'd9 : 5'd0, i == 1, 1'b1,
                  mw[i] + 1, i == 0);
         drive(ins[i], 0, mw[i], 1'b0, o);
         e = exp_q.pop_front();
         n_tests++; if (o.pc !== e.pc) begin n_fail++; $display("FAIL mem%0d_pc got %h want %h", i, o.pc, e.pc); end
         n_tests++; if (o.cycles != e.cycles) begin n_fail++; $display("FAIL mem%0d_cycles got %0d want %0d", i, o.cycles, e.cycles); end
         n_tests++; if (o.trace !== e.trace) begin n_fail++; $display("FAIL mem%0d_trace got %o want %o", i, o.trace, e.trace); end
         n_tests++; if (o.mem_cycles != e.mem_cycles || o.mem_we !== e.mem_we) begin
            n_fail++; $display("FAIL mem%0d_access got %0d cyc we%b want %0d cyc we%b", i, o.mem_cycles, o.mem_we, e.mem_cycles, e.mem_we); end
         n_tests++; if (o.we !== e.we || o.waddr !== e.waddr || o.rsel !== e.rsel) begin
            n_fail++; $display("FAIL mem%0d_wb got we%b a%0d s%b want we%b a%0d s%b", i, o.we, o.waddr, o.rsel, e.we, e.waddr, e.rsel); end
         n_tests++; if (o.alu2 !== e.alu2 || o.bad !== 1'b0 || o.retire_after !== 1'b0) begin
            n_fail++; $display("FAIL mem%0d_protocol got alu2=%b bad=%b ra=%b want 1 0 0", i, o.alu2, o.bad, o.retire_after); end
         $display("[TB] mem%0d ins=%h pc=%h cycles=%0d memcyc=%0d", i, ins[i], o.pc, o.cycles, o.mem_cycles);
      end
   endtask

   task automatic test_jump_branch();
      logic [31:0] ins[3] = '{32'h08000010, 32'h11090003, 32'h11090003};
      logic        zf[3]  = '{1'b0, 1'b1, 1'b0};
      logic [31:0] ba[3]  = '{32'h0, 32'h40, 32'h80};
      rec_t o, e;
      jump_address = 32'h200;
      for (int i = 0; i < 3; i++) begin
         branch_address = ba[i];
         if (i == 0)      pc_model = 32'h200;
         else if (zf[i])  pc_model = ba[i];
         else             pc_model = pc_model + 32'd4;
         push_exp(pc_model, (i == 0) ? 2 : 3, (i == 0) ? 30'o1 : 30'o12, 1'b0, 5'd0, 1'b0, 1'b0, 0, 1'b0);
         drive(ins[i], 0, 0, zf[i], o);
         e = exp_q.pop_front();
         n_tests++; if (o.pc !== e.pc) begin n_fail++; $display("FAIL br%0d_pc got %h want %h", i, o.pc, e.pc); end
         n_tests++; if (o.cycles != e.cycles) begin n_fail++; $display("FAIL br%0d_cycles got %0d want %0d", i, o.cycles, e.cycles); end
         n_tests++; if (o.trace !== e.trace) begin n_fail++; $display("FAIL br%0d_trace got %o want %o", i, o.trace, e.trace); end
         n_tests++; if (o.we !== e.we || o.alu2 !== e.alu2 || o.bad !== 1'b0 || o.retire_after !== 1'b0) begin
            n_fail++; $display("FAIL br%0d_ctrl got we=%b alu2=%b bad=%b ra=%b want 0 0 0 0", i, o.we, o.alu2, o.bad, o.retire_after); end
         $display("[TB] br%0d ins=%h zero=%b pc=%h cycles=%0d", i, ins[i], zf[i], o.pc, o.cycles);
      end
   endtask

   task automatic test_trap();
      logic [31:0] frozen;
      int bad = 0;
      instrn = 32'hFC000000;
      mem_ready = 1'b1;
      step();
      step();
      frozen = pc_model + 32'd4;
      n_tests++; if (state !== 3'd5 || illegal !== 1'b1) begin
         n_fail++; $display("FAIL trap_entry got state %0d illegal %b want 5 1", state, illegal); end
      for (int c = 0; c < 20; c++) begin
         if (retire || pc !== frozen || ir !== 32'hFC000000 || mem_req || mem_we || ctrl_write_en || state !== 3'd5 || !illegal) bad++;
         step();
      end
      n_tests++; if (bad != 0) begin n_fail++; $display("FAIL trap_hold got %0d bad cycles want 0", bad); end
      rst = 1'b1;
      step();
      n_tests++; if (illegal !== 1'b0 || pc !== RPC || state !== 3'd0) begin
         n_fail++; $display("FAIL trap_reset got illegal %b pc %h state %0d want 0 %h 0", illegal, pc, state, RPC); end
      rst = 1'b0;
      mem_ready = 1'b0;
      pc_model = RPC;
      $display("[TB] trap: held %0d cycles, bad=%0d, cleared by rst", 20, bad);
   endtask

   task automatic test_reset_mid_mem();
      instrn = 32'hAD090008;
      mem_ready = 1'b1;
      step();
      step();
      step();
      mem_ready = 1'b0;
      step();
      n_tests++; if (state !== 3'd3 || mem_req !== 1'b1 || mem_we !== 1'b1) begin
         n_fail++; $display("FAIL midmem_setup got state %0d req %b we %b want 3 1 1", state, mem_req, mem_we); end
      rst = 1'b1;
      step();
      n_tests++; if (state !== 3'd0 || mem_req !== 1'b0 || mem_we !== 1'b0 || pc !== RPC) begin
         n_fail++; $display("FAIL midmem_reset got state %0d req %b we %b pc %h want 0 0 0 %h", state, mem_req, mem_we, pc, RPC); end
      n_tests++; if (state8 !== 3'd0 || mem_req8 !== 1'b0 || pc8 !== RPC8) begin
         n_fail++; $display("FAIL midmem_reset8 got state %0d req %b pc %h want 0 0 %h", state8, mem_req8, pc8, RPC8); end
      rst = 1'b0;
      pc_model = RPC;
      $display("[TB] midmem reset: state=%0d mem_req=%b pc=%h", state, mem_req, pc);
   endtask

   initial begin
      test_reset();
      test_alu();
      test_load_store();
      test_jump_branch();
      test_trap();
      test_reset_mid_mem();
      $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
      $finish;
   end

endmodule
